// File: rtl/pll_cfg_pkg.sv
// Shared constants and types for the PLL underclock reconfiguration sequencer.
package pll_cfg_pkg;

    localparam logic [5:0]  REG_MODE        = 6'd0;
    localparam logic [5:0]  REG_START       = 6'd2;
    localparam logic [5:0]  REG_FRAC_K      = 6'd7;

    localparam logic [31:0] FRAC_NATIVE_DEF = 32'd3639383488;
    localparam logic [31:0] FRAC_UNDER_DEF  = 32'd3268298314;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_MODE,
        ST_WR_K,
        ST_WR_START,
        ST_GUARD,
        ST_WAIT_LOCK,
        ST_FAULT
    } seq_state_t;

    // Counter width for a terminal count of limit-1; never narrower than one bit.
    function automatic int cnt_w(input int limit);
        return (limit < 2) ? 1 : $clog2(limit);
    endfunction

endpackage

// File: rtl/sync_filter.sv
// Two-flop synchronizer with an optional stability filter on the synced level.
module sync_filter
    import pll_cfg_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_async,
    output logic o_out
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    generate
        if (STABLE_CYCLES <= 1) begin : g_bypass
            assign o_out = r_sync;
        end else begin : g_filt
            localparam int              CW   = cnt_w(STABLE_CYCLES);
            localparam logic [CW-1:0]   LAST = CW'(STABLE_CYCLES - 1);

            logic [CW-1:0] r_cnt;
            logic          r_stable;

            // A one-bit level differing from the accepted value is the only
            // candidate, so any flip back restarts the run.
            always_ff @(posedge i_clk or posedge i_reset) begin
                if (i_reset) begin
                    r_cnt    <= '0;
                    r_stable <= 1'b0;
                end else if (r_sync == r_stable) begin
                    r_cnt    <= '0;
                end else if (r_cnt == LAST) begin
                    r_cnt    <= '0;
                    r_stable <= r_sync;
                end else begin
                    r_cnt    <= r_cnt + 1'b1;
                end
            end

            assign o_out = r_stable;
        end
    endgenerate

endmodule

// File: rtl/pll_underclock_seq.sv
// Avalon-MM master that reprograms the PLL fractional-K word when the
// Game Speed request changes, then supervises lock with a timeout.
module pll_underclock_seq
    import pll_cfg_pkg::*;
#(
    parameter logic [31:0] FRAC_NATIVE   = FRAC_NATIVE_DEF,
    parameter logic [31:0] FRAC_UNDER    = FRAC_UNDER_DEF,
    parameter int          STABLE_CYCLES = 4,
    parameter int          LOCK_GUARD    = 16,
    parameter int          LOCK_TIMEOUT  = 5000000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_underclock_req,
    input  logic        i_pll_locked,
    input  logic        i_mgmt_waitrequest,
    output logic        o_mgmt_write,
    output logic [5:0]  o_mgmt_address,
    output logic [31:0] o_mgmt_writedata,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_lock_timeout,
    output logic        o_applied_underclock
);

    localparam int            GW         = cnt_w(LOCK_GUARD);
    localparam int            TW         = cnt_w(LOCK_TIMEOUT);
    localparam logic [GW-1:0] GUARD_LAST = GW'(LOCK_GUARD - 1);
    localparam logic [TW-1:0] TO_LAST    = TW'(LOCK_TIMEOUT - 1);

    logic w_req;
    logic w_locked;

    sync_filter #(.STABLE_CYCLES(STABLE_CYCLES)) u_req_filt (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_async (i_underclock_req),
        .o_out   (w_req)
    );

    sync_filter #(.STABLE_CYCLES(1)) u_lock_sync (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_async (i_pll_locked),
        .o_out   (w_locked)
    );

    seq_state_t    r_state, w_next;
    logic          r_gap, w_gap_nxt;
    logic          r_target, w_target_nxt;
    logic          r_applied, w_applied_nxt;
    logic          r_lto, w_lto_nxt;
    logic [GW-1:0] r_gcnt, w_gcnt_nxt;
    logic [TW-1:0] r_tcnt, w_tcnt_nxt;
    logic          w_write;
    logic          w_done;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= ST_IDLE;
            r_gap     <= 1'b0;
            r_target  <= 1'b0;
            r_applied <= 1'b0;
            r_lto     <= 1'b0;
            r_gcnt    <= '0;
            r_tcnt    <= '0;
        end else begin
            r_state   <= w_next;
            r_gap     <= w_gap_nxt;
            r_target  <= w_target_nxt;
            r_applied <= w_applied_nxt;
            r_lto     <= w_lto_nxt;
            r_gcnt    <= w_gcnt_nxt;
            r_tcnt    <= w_tcnt_nxt;
        end
    end

    always_comb begin
        w_next        = r_state;
        w_gap_nxt     = r_gap;
        w_target_nxt  = r_target;
        w_applied_nxt = r_applied;
        w_lto_nxt     = r_lto;
        w_gcnt_nxt    = r_gcnt;
        w_tcnt_nxt    = r_tcnt;
        w_write       = 1'b0;
        w_done        = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_req != r_applied) begin
                    w_target_nxt = w_req;
                    w_gap_nxt    = 1'b0;
                    w_next       = ST_WR_MODE;
                end
            end
            ST_WR_MODE, ST_WR_K, ST_WR_START: begin
                // r_gap marks the idle cycle that follows each accepted write.
                w_write = !r_gap;
                if (r_gap) begin
                    w_gap_nxt = 1'b0;
                    case (r_state)
                        ST_WR_MODE: w_next = ST_WR_K;
                        ST_WR_K:    w_next = ST_WR_START;
                        default: begin
                            w_next     = ST_GUARD;
                            w_gcnt_nxt = '0;
                        end
                    endcase
                end else if (!i_mgmt_waitrequest) begin
                    w_gap_nxt = 1'b1;
                end
            end
            ST_GUARD: begin
                if (r_gcnt == GUARD_LAST) begin
                    w_next     = ST_WAIT_LOCK;
                    w_tcnt_nxt = '0;
                end else begin
                    w_gcnt_nxt = r_gcnt + 1'b1;
                end
            end
            ST_WAIT_LOCK: begin
                if (w_locked) begin
                    w_done        = 1'b1;
                    w_applied_nxt = r_target;
                    w_lto_nxt     = 1'b0;
                    w_next        = ST_IDLE;
                end else if (r_tcnt == TO_LAST) begin
                    w_next = ST_FAULT;
                end else begin
                    w_tcnt_nxt = r_tcnt + 1'b1;
                end
            end
            ST_FAULT: begin
                // The new word is in the PLL even though lock never came.
                w_lto_nxt     = 1'b1;
                w_applied_nxt = r_target;
                w_next        = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign o_mgmt_write         = w_write;
    assign o_mgmt_address       = (r_state == ST_WR_K)     ? REG_FRAC_K :
                                  (r_state == ST_WR_START) ? REG_START  : REG_MODE;
    assign o_mgmt_writedata     = (r_state == ST_WR_K) ? (r_target ? FRAC_UNDER : FRAC_NATIVE) : 32'd0;
    assign o_busy               = (r_state != ST_IDLE);
    assign o_done               = w_done;
    assign o_lock_timeout       = r_lto;
    assign o_applied_underclock = r_applied;

endmodule

// File: doc/pll_underclock_seq.md
Name: pll_underclock_seq

Overview:
- Avalon-MM master sequencer that drives the PLL reconfiguration controller (pll_cfg management port) from the OSD "Game Speed" bit.
- Switches the video/system PLL between native and ~1% underclocked fractional settings (60Hz adjust).
- Replaces the ad-hoc always block in emu.
- Sits on the CLK_50M management domain, between hps_io status and pll_cfg.
- Adds request filtering, handshake-correct writes, lock supervision and status outputs.

Parameters:
- FRAC_NATIVE, 32'd3639383488, fractional-K word for native speed
- FRAC_UNDER, 32'd3268298314, fractional-K word for 60Hz adjust
- STABLE_CYCLES, 4, synced request must hold this many clk cycles before acceptance (>=1)
- LOCK_GUARD, 16, cycles after START write during which locked is ignored
- LOCK_TIMEOUT, 5000000, max cycles waiting for lock (100 ms at 50 MHz)

Ports:
- clk, in, 1, management clock (CLK_50M)
- reset, in, 1, asynchronous active-high reset
- underclock_req, in, 1, requested mode (status[21]), asynchronous to clk
- pll_locked, in, 1, PLL locked, asynchronous to clk
- mgmt_waitrequest, in, 1, Avalon waitrequest from pll_cfg
- mgmt_write, out, 1, Avalon write strobe
- mgmt_address, out, 6, register address
- mgmt_writedata, out, 32, register data
- busy, out, 1, reconfiguration in progress
- done, out, 1, one-cycle pulse on successful completion
- lock_timeout, out, 1, sticky lock failure flag
- applied_underclock, out, 1, mode currently programmed in the PLL

Behaviour:
- Reset values:
  - mgmt_write=0, mgmt_address=0, mgmt_writedata=0, busy=0, done=0, lock_timeout=0, applied_underclock=0.
  - applied_underclock=0 means the compiled PLL default is native, so no reconfiguration runs unless the request is 1.
  - Reset asserted mid-operation aborts immediately to IDLE with these values and leaves no write pending.
- Input synchronization: underclock_req and pll_locked each pass through a 2-flop synchronizer (also reset to 0).
- Request filter:
  - Counter restarts whenever the synced request changes.
  - The request is accepted (stable_req) after STABLE_CYCLES consecutive equal samples.
- FSM states: IDLE, WR_MODE, WR_K, WR_START, GUARD, WAIT_LOCK, FAULT.
- IDLE: if stable_req != applied_underclock, latch target=stable_req, set busy=1, go to WR_MODE. The target is frozen for the rest of the sequence.
- Write states (WR_MODE addr 0 data 0; WR_K addr 7 data FRAC_UNDER/FRAC_NATIVE per target; WR_START addr 2 data 0):
  - Entering the state: drive address/data and mgmt_write=1 on the same cycle.
  - Hold all three stable while mgmt_waitrequest=1.
  - The transfer completes on the first rising edge with mgmt_write=1 and mgmt_waitrequest=0.
  - The next cycle drives mgmt_write=0, forming one mandatory idle gap cycle, then advances.
- GUARD: count LOCK_GUARD cycles, then go to WAIT_LOCK with the timeout counter cleared.
- WAIT_LOCK:
  - On synced locked=1: applied_underclock<=target, lock_timeout<=0, done=1 for one cycle, busy<=0, go to IDLE.
  - If the timeout counter reaches LOCK_TIMEOUT-1 first: go to FAULT.
- FAULT (one cycle): lock_timeout<=1, applied_underclock<=target (the PLL is programmed regardless), busy<=0, go to IDLE.
- Request toggled during a sequence: no abort. After return to IDLE, a differing stable_req starts a fresh sequence. Minimum IDLE dwell is one cycle.
- Counter widths are $clog2 of their limits. Counters saturate and never wrap.
- done and the start of a new sequence never coincide: the start occurs at the earliest one cycle after done.

Decomposition:
- Shared package pll_cfg_pkg holds:
  - register address constants (REG_MODE=6'd0, REG_START=6'd2, REG_FRAC_K=6'd7)
  - the state enum typedef
  - the default FRAC words
- One natural sub-module: sync_filter. It contains the 2-flop synchronizer plus the stability counter, parameterised by STABLE_CYCLES.
- It is instantiated for the request path. The locked path uses the 2-flop part only, with STABLE_CYCLES=1.

Test Plan:
- Reset, request held at 0 for 1000 cycles -> no mgmt_write ever; busy=0; applied_underclock=0.
- Request 0->1 with waitrequest=0 and locked held 1 -> three writes in order (addr0/0, addr7/3268298314, addr2/0), each with one gap cycle. done pulses once after the GUARD window; applied_underclock=1.
- waitrequest held high 5 cycles on the addr7 write -> mgmt_write, address and data are stable for all 6 cycles; a single transfer is counted.
- 2-cycle glitch on request with STABLE_CYCLES=4 -> no sequence starts. A toggle mid-sequence (1->0 during WR_K) -> the first sequence completes to 1, then a second sequence writes 3639383488.
- locked held 0 after START -> lock_timeout=1 exactly LOCK_TIMEOUT cycles after GUARD ends (scale LOCK_TIMEOUT=100 in bench); applied_underclock=1. The next successful sequence clears lock_timeout.
- Reset asserted while holding a write under waitrequest -> mgmt_write=0 and busy=0 asynchronously. After release, a still-differing request restarts from WR_MODE.
